// File: rtl/registers_bank_dumper_pkg.sv
// ============================================================================
// registers_bank_dumper_pkg : state encoding and beat width shared by the
//                             dumper, the debug-unit top and the bench
// Revision : 1.0
// ============================================================================
`default_nettype none

package registers_bank_dumper_pkg;

  localparam int BYTE_SIZE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } dumper_state_t;

endpackage

`default_nettype wire

// File: rtl/registers_bank_dumper.sv
// ============================================================================
// registers_bank_dumper : snapshots the flattened register bank on request and
//                         streams it out byte by byte over valid/ready
// Revision : 1.0
// ============================================================================
`default_nettype none

module registers_bank_dumper
  import registers_bank_dumper_pkg::*;
#(
  parameter int REGISTERS_BANK_SIZE = 32,
  parameter int REGISTERS_SIZE      = 32
) (
  input  logic                                        i_clk,
  input  logic                                        i_reset,
  input  logic                                        i_flush,
  input  logic                                        i_start,
  input  logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] i_bus_debug,
  input  logic                                        i_ready,
  output logic [BYTE_SIZE-1:0]                        o_data,
  output logic                                        o_valid,
  output logic                                        o_busy,
  output logic                                        o_done
);

  localparam int TOTAL_BITS  = REGISTERS_BANK_SIZE * REGISTERS_SIZE;
  localparam int TOTAL_BYTES = TOTAL_BITS / BYTE_SIZE;
  localparam int CNT_W       = $clog2(TOTAL_BYTES + 1);

  generate
    if ((REGISTERS_SIZE % BYTE_SIZE) != 0) begin : g_bad_register_size
      $error("registers_bank_dumper: REGISTERS_SIZE must be a multiple of 8");
    end
  endgenerate

  dumper_state_t           state;
  dumper_state_t           state_next;
  logic [TOTAL_BITS-1:0]   snapshot;
  logic [CNT_W-1:0]        count;
  logic                    load;
  logic                    shift;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A beat accepted in the flush cycle still shifts; the snapshot is dead afterwards anyway.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start && !i_flush) begin
          load       = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        shift = i_ready;
        if (i_flush) begin
          state_next = ST_IDLE;
        end else if (i_ready && (count == CNT_W'(1))) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      snapshot <= '0;
      count    <= '0;
    end else if (load) begin
      snapshot <= i_bus_debug;
      count    <= CNT_W'(TOTAL_BYTES);
    end else if (shift) begin
      snapshot <= snapshot >> BYTE_SIZE;
      count    <= count - CNT_W'(1);
    end
  end

  assign o_data  = snapshot[BYTE_SIZE-1:0];
  assign o_valid = (state == ST_SEND);
  assign o_done  = (state == ST_DONE);
  assign o_busy  = (state != ST_IDLE);

endmodule

`default_nettype wire
